// File: rtl/lcd_field_writer.sv
// rtl/lcd_field_writer.sv - streams NUM_FIELDS label+BCD fields into the LCD character buffer
// Optional leading-zero blanking is enabled by defining LCD_LZB_EN.
module lcd_field_writer #(
  parameter int         NUM_FIELDS  = 4,
  parameter int         LABEL_LEN   = 5,
  parameter int         DIGITS      = 3,
  parameter int         ADDR_W      = 5,
  parameter int         BASE_ADDR   = 0,
  parameter int         REFRESH_DIV = 1000000,
  parameter logic [7:0] BLANK_CHAR  = 8'hFE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FIELDS*DIGITS*4-1:0]    bcd_in,
  input  logic [NUM_FIELDS*LABEL_LEN*8-1:0] label_chars,
  input  logic                              force_update,
  input  logic                              wr_ready,
  output logic                              wr_en,
  output logic [ADDR_W-1:0]                 wr_addr,
  output logic [7:0]                        wr_data,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int CHARS = LABEL_LEN + DIGITS;
  localparam int BCD_W = NUM_FIELDS * DIGITS * 4;
  localparam int LBL_W = NUM_FIELDS * LABEL_LEN * 8;
  localparam int FW    = (NUM_FIELDS > 1)  ? $clog2(NUM_FIELDS)  : 1;
  localparam int PW    = (CHARS > 1)       ? $clog2(CHARS)       : 1;
  localparam int CW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CW-1:0]     CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0]     FIELD_LAST = FW'(NUM_FIELDS - 1);
  localparam logic [PW-1:0]     POS_LAST   = PW'(CHARS - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BASE_ADDR);

`ifdef LCD_LZB_EN
  localparam bit LZB_ON = 1'b1;
`else
  localparam bit LZB_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              pending, pending_d;
  logic [BCD_W-1:0]  snap, snap_d;
  logic [FW-1:0]     field_q, field_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic              wr_en_d, busy_d, frame_done_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;

  // Character at (field f, position p); loops keep every select index constant.
  function automatic logic [7:0] char_at(input int f, input int p,
                                         input logic [BCD_W-1:0] b,
                                         input logic [LBL_W-1:0] l);
    logic [7:0] c;
    logic [3:0] nib;
    logic       lead;
    c = 8'h00;
    for (int ff = 0; ff < NUM_FIELDS; ff++) begin
      lead = 1'b1;
      for (int k = 0; k < LABEL_LEN; k++)
        if (ff == f && k == p) c = l[(ff*LABEL_LEN+k)*8 +: 8];
      for (int d = 0; d < DIGITS; d++) begin
        nib = b[(ff*DIGITS + DIGITS-1-d)*4 +: 4];
        if (ff == f && LABEL_LEN + d == p) begin
          if (nib > 4'd9) c = 8'h3F;
          else            c = 8'h30 | {4'h0, nib};
          if (LZB_ON && lead && nib == 4'd0 && d != DIGITS-1) c = BLANK_CHAR;
        end
        if (nib != 4'd0) lead = 1'b0;
      end
    end
    return c;
  endfunction

  always_comb begin
    state_d      = state;
    cnt_d        = '0;
    pending_d    = pending | (force_update && (state != IDLE));
    snap_d       = snap;
    field_d      = field_q;
    pos_d        = pos_q;
    wr_en_d      = wr_en;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    busy_d       = busy;
    frame_done_d = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = cnt + CW'(1);
        if ((cnt == CNT_LAST) || force_update || pending) begin
          state_d   = LOAD;
          cnt_d     = '0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      LOAD: begin
        // First character is presented straight from the live inputs being snapshotted.
        snap_d    = bcd_in;
        field_d   = '0;
        pos_d     = '0;
        state_d   = WRITE;
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_FIRST;
        wr_data_d = char_at(0, 0, bcd_in, label_chars);
      end
      WRITE: begin
        if (wr_ready) begin
          if (field_q == FIELD_LAST && pos_q == POS_LAST) begin
            state_d      = DONE;
            wr_en_d      = 1'b0;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            if (pos_q == POS_LAST) begin
              pos_d   = '0;
              field_d = field_q + FW'(1);
            end else begin
              pos_d = pos_q + PW'(1);
            end
            wr_addr_d = wr_addr + ADDR_W'(1);
            wr_data_d = char_at(int'(field_d), int'(pos_d), snap, label_chars);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      snap       <= '0;
      field_q    <= '0;
      pos_q      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      pending    <= pending_d;
      snap       <= snap_d;
      field_q    <= field_d;
      pos_q      <= pos_d;
      wr_en      <= wr_en_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule
